pipe_perf_monitor: RTL and testbench
====================================

# pipe_perf_monitor

Parametrised retirement monitor for the pipelined RISC-V cores. It taps the core debug outputs: `pc_debug`, `insn_vld`, `ctrl` and `mispred`. From these it accumulates cycle, retire, bubble, control-transfer and misprediction counts, detects the end-of-program self-loop, and enforces a cycle watchdog. It replaces the fixed-timeout, bench-only completion check with synthesizable logic. The same block serves both the forwarding and non-forwarding pipelines, in simulation and on the board.

## Interface
- `PC_W`, 32, width of the PC tap.
- `CNT_W`, 32, width of every event counter.
- `TIMEOUT`, 50_000, number of RUN cycles before the watchdog fires. 0 disables the watchdog. Must be < 2^CNT_W.
- `HALT_REPEAT`, 4, number of consecutive valid retirements at one PC that declares a halt. Must be ≥ 2.
- `i_clk`  in  1  core clock; single clock domain.
- `i_reset`  in  1  synchronous, active-low reset.
- `i_clear`  in  1  synchronous soft clear. Same effect as reset; reset has priority.
- `i_pc_debug`  in  PC_W  PC of the retiring instruction.
- `i_insn_vld`  in  1  an instruction retires this cycle.
- `i_ctrl`  in  1  the retiring instruction is a branch or jump.
- `i_mispred`  in  1  the retiring instruction was mispredicted.
- `o_state`  out  2  00 IDLE, 01 RUN, 10 DONE, 11 TOUT.
- `o_done`  out  1  halt detected; sticky.
- `o_timeout`  out  1  watchdog expired; sticky.
- `o_cycles`, `o_insns`, `o_bubbles`, `o_ctrl_cnt`, `o_mispred_cnt`  out  CNT_W each  event counters.
- `o_halt_pc`  out  PC_W  PC at which the halt was detected.

## Operation
- State machine:
  - IDLE → RUN on the first cycle with `i_insn_vld`=1. That cycle is counted.
  - RUN → DONE on halt detection.
  - RUN → TOUT on watchdog expiry.
  - DONE and TOUT are terminal until reset or clear.
- Counting (RUN, including the entry cycle):
  - `o_cycles` += 1 every cycle.
  - `o_insns` += vld.
  - `o_bubbles` += !vld.
  - `o_ctrl_cnt` += vld & ctrl.
  - `o_mispred_cnt` += vld & mispred.
  - `ctrl` and `mispred` are ignored when vld=0.
- Counters freeze in IDLE, DONE and TOUT.
- Every counter saturates at 2^CNT_W−1. It never wraps.
- Halt detection:
  - Internal `last_pc` and repeat counter `rep`.
  - On each vld cycle: if `pc == last_pc`, rep += 1 (saturating at HALT_REPEAT); otherwise rep = 1. Then `last_pc` = pc.
  - Bubbles leave `rep` and `last_pc` unchanged.
  - The first retirement after IDLE always sets rep = 1.
  - Halt fires on the vld cycle that makes rep == HALT_REPEAT. `o_halt_pc` = that pc.
- Watchdog: fires on the RUN cycle that makes `o_cycles` == TIMEOUT, when TIMEOUT ≠ 0.
- Simultaneous halt and watchdog on the same cycle: DONE wins, `o_timeout` stays 0.
- Reset or clear mid-operation:
  - Returns to IDLE on the next edge.
  - Zeroes every counter, `rep`, `last_pc` and `o_halt_pc`.
  - Clears `o_done` and `o_timeout`.

## Timing
- All outputs are registered.
- An event sampled at edge N is visible on the outputs after edge N, in the same cycle it is counted. Latency is 1 cycle.
- `o_done`, `o_timeout` and `o_state` change on the same edge as the final counter update. The counters already include the terminating cycle.
- Reset values:
  - `o_state` = 00.
  - `o_done` = `o_timeout` = 0.
  - All counters = 0.
  - `o_halt_pc` = 0.
- No handshake. The inputs are assumed stable at the sampling edge, as the core drives them from its writeback registers.
- Counter update, halt compare and watchdog compare all use pre-edge values. There are no combinational paths from inputs to outputs.

## Test plan
- **Reset:**
  - Hold `i_reset`=0 for 5 cycles with random inputs.
  - Expect `o_state`=00, all counters 0, `o_done`=`o_timeout`=0.
  - Release with vld=0 for 10 cycles. Expect state still IDLE and counters still 0.
- **Normal halt** (HALT_REPEAT=4, TIMEOUT=100). Stimulus:
  - vld at pc 0x0, then vld at 0x4, then one bubble.
  - vld at 0x8 with ctrl=1, mispred=1.
  - vld at 0x40 on four consecutive cycles.
  - Expect DONE after the 4th 0x40, with `o_cycles`=8, `o_insns`=7, `o_bubbles`=1, `o_ctrl_cnt`=1, `o_mispred_cnt`=1, `o_halt_pc`=0x40.
  - Counters stay frozen for 20 more cycles.
- **Bubbles inside the repeat:**
  - Sequence 0x40, 0x40, bubble, bubble, 0x40, 0x40.
  - Expect DONE on the last one, `o_bubbles`=2.
  - Separately, sequence 0x40, 0x40, 0x44, 0x40 leaves rep=1, so no halt.
- **Watchdog** (TIMEOUT=100):
  - Continuous vld with PC incrementing by 4.
  - Expect `o_timeout`=1 and state TOUT after exactly 100 RUN cycles, with `o_cycles`=100 and `o_insns`=100, then frozen.
- **Simultaneous events** (TIMEOUT=100, HALT_REPEAT=4):
  - The 4th repeat lands on RUN cycle 100.
  - Expect `o_done`=1, `o_timeout`=0, state DONE.
- **Saturation and clear** (CNT_W=4, TIMEOUT=0):
  - 20 vld cycles at distinct PCs. Expect `o_cycles`=`o_insns`=15 and state still RUN.
  - Pulse `i_clear` for 1 cycle. Expect IDLE and all zeros on the next edge.

Source files
------------

// File: rtl/pipe_perf_monitor.sv
// Purpose : retirement monitor; counts cycles/retires/bubbles/ctrl/mispred, detects self-loop halt, runs a cycle watchdog.
// Latency : 1 cycle; an event sampled at edge N is reflected on every output right after edge N.
// Backpressure: none; a passive tap on the core debug outputs that can never stall the core.
//
// Ports:
//   i_clk, i_reset (sync, active-low), i_clear (sync soft clear, reset has priority)
//   i_pc_debug / i_insn_vld / i_ctrl / i_mispred : retirement tap from the core writeback stage
//   o_state (00 IDLE, 01 RUN, 10 DONE, 11 TOUT), o_done / o_timeout (sticky)
//   o_cycles, o_insns, o_bubbles, o_ctrl_cnt, o_mispred_cnt : saturating event counters
//   o_halt_pc : PC of the self-loop that ended the run
module pipe_perf_monitor #(
    parameter int PC_W        = 32,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT     = 50_000,
    parameter int HALT_REPEAT = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic [PC_W-1:0]  i_pc_debug,
    input  logic             i_insn_vld,
    input  logic             i_ctrl,
    input  logic             i_mispred,
    output logic [1:0]       o_state,
    output logic             o_done,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_cycles,
    output logic [CNT_W-1:0] o_insns,
    output logic [CNT_W-1:0] o_bubbles,
    output logic [CNT_W-1:0] o_ctrl_cnt,
    output logic [CNT_W-1:0] o_mispred_cnt,
    output logic [PC_W-1:0]  o_halt_pc
);

    localparam int               REP_W    = $clog2(HALT_REPEAT + 1);
    localparam logic [REP_W-1:0] REP_HALT = REP_W'(HALT_REPEAT);
    localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10,
        TOUT = 2'b11
    } state_t;

    state_t           state;
    logic [PC_W-1:0]  last_pc;
    logic [REP_W-1:0] rep;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        sat_inc = (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
    endfunction

    logic             first;
    logic             active;
    logic [REP_W-1:0] rep_nxt;
    logic [CNT_W-1:0] cycles_nxt;
    logic             halt;
    logic             wdog;

    always_comb begin
        first  = (state == IDLE);
        // The retirement that wakes us from IDLE is itself counted.
        active = (state == RUN) || (first && i_insn_vld);

        // last_pc is stale on the entry cycle, so the first retirement restarts the run length.
        if (!i_insn_vld)
            rep_nxt = rep;
        else if (first || (i_pc_debug != last_pc))
            rep_nxt = REP_W'(1);
        else if (rep < REP_HALT)
            rep_nxt = rep + REP_W'(1);
        else
            rep_nxt = rep;

        cycles_nxt = sat_inc(o_cycles, 1'b1);
        halt       = i_insn_vld && (rep_nxt == REP_HALT);
        wdog       = (TIMEOUT != 0) && (cycles_nxt == TMO);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset || i_clear) begin
            state         <= IDLE;
            o_done        <= 1'b0;
            o_timeout     <= 1'b0;
            o_cycles      <= '0;
            o_insns       <= '0;
            o_bubbles     <= '0;
            o_ctrl_cnt    <= '0;
            o_mispred_cnt <= '0;
            o_halt_pc     <= '0;
            last_pc       <= '0;
            rep           <= '0;
        end else if (active) begin
            o_cycles      <= cycles_nxt;
            o_insns       <= sat_inc(o_insns, i_insn_vld);
            o_bubbles     <= sat_inc(o_bubbles, !i_insn_vld);
            o_ctrl_cnt    <= sat_inc(o_ctrl_cnt, i_insn_vld & i_ctrl);
            o_mispred_cnt <= sat_inc(o_mispred_cnt, i_insn_vld & i_mispred);
            rep           <= rep_nxt;
            if (i_insn_vld)
                last_pc <= i_pc_debug;
            // Halt outranks the watchdog when both land on the same cycle.
            if (halt) begin
                state     <= DONE;
                o_done    <= 1'b1;
                o_halt_pc <= i_pc_debug;
            end else if (wdog) begin
                state     <= TOUT;
                o_timeout <= 1'b1;
            end else begin
                state <= RUN;
            end
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Purpose : bench for pipe_perf_monitor; two instances (32-bit counters with TIMEOUT=100, 4-bit counters without watchdog).
// Latency : expected outputs are queued per stimulus cycle and compared one cycle later by a monitor.
// Backpressure: not applicable; the DUT has no handshake.
module tb_pipe_perf_monitor;

    localparam int HR = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic        vld = 1'b0;
    logic        ctl = 1'b0;
    logic        mp  = 1'b0;
    logic [31:0] pc  = '0;

    logic [1:0]  st_a, st_b;
    logic        done_a, done_b, tout_a, tout_b;
    logic [31:0] cyc_a, ins_a, bub_a, ctl_a, mis_a, hpc_a, hpc_b;
    logic [3:0]  cyc_b, ins_b, bub_b, ctl_b, mis_b;

    always #5 clk = ~clk;

    pipe_perf_monitor #(.PC_W(32), .CNT_W(32), .TIMEOUT(100), .HALT_REPEAT(HR)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_clear(clr), .i_pc_debug(pc), .i_insn_vld(vld),
        .i_ctrl(ctl), .i_mispred(mp), .o_state(st_a), .o_done(done_a), .o_timeout(tout_a),
        .o_cycles(cyc_a), .o_insns(ins_a), .o_bubbles(bub_a), .o_ctrl_cnt(ctl_a),
        .o_mispred_cnt(mis_a), .o_halt_pc(hpc_a)
    );

    pipe_perf_monitor #(.PC_W(32), .CNT_W(4), .TIMEOUT(0), .HALT_REPEAT(HR)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_clear(clr), .i_pc_debug(pc), .i_insn_vld(vld),
        .i_ctrl(ctl), .i_mispred(mp), .o_state(st_b), .o_done(done_b), .o_timeout(tout_b),
        .o_cycles(cyc_b), .o_insns(ins_b), .o_bubbles(bub_b), .o_ctrl_cnt(ctl_b),
        .o_mispred_cnt(mis_b), .o_halt_pc(hpc_b)
    );

    typedef struct packed {
        logic [1:0]  st;
        logic        done;
        logic        tout;
        logic [31:0] cyc;
        logic [31:0] ins;
        logic [31:0] bub;
        logic [31:0] ctl;
        logic [31:0] mis;
        logic [31:0] hpc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one entry per instance.
    int          m_st[2];
    bit          m_done[2];
    bit          m_tout[2];
    longint      m_cnt[2][5];   // cycles, insns, bubbles, ctrl, mispred
    logic [31:0] m_hpc[2];
    longint      m_max[2] = '{64'd4294967295, 64'd15};
    longint      m_tmo[2] = '{64'd100, 64'd0};
    logic [31:0] hist[$];       // valid PCs retired since the run started (last HR kept)

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_step(input bit r, input bit c, input bit v, input logic [31:0] p,
                              input bit ct, input bit mq);
        bit halt_now;
        if (!r || c) begin
            hist.delete();
            for (int m = 0; m < 2; m++) begin
                m_st[m] = 0; m_done[m] = 0; m_tout[m] = 0; m_hpc[m] = '0;
                for (int k = 0; k < 5; k++) m_cnt[m][k] = 0;
            end
            return;
        end
        if (v) begin
            if (m_st[0] == 0) hist.delete();
            hist.push_back(p);
            if (hist.size() > HR) void'(hist.pop_front());
        end
        halt_now = v && (hist.size() == HR);
        if (halt_now)
            foreach (hist[i]) if (hist[i] != p) halt_now = 0;
        for (int m = 0; m < 2; m++) begin
            if (m_st[m] == 1 || (m_st[m] == 0 && v)) begin
                m_cnt[m][0] = sat(m_cnt[m][0] + 1, m_max[m]);
                m_cnt[m][1] = sat(m_cnt[m][1] + (v ? 1 : 0), m_max[m]);
                m_cnt[m][2] = sat(m_cnt[m][2] + (v ? 0 : 1), m_max[m]);
                m_cnt[m][3] = sat(m_cnt[m][3] + ((v && ct) ? 1 : 0), m_max[m]);
                m_cnt[m][4] = sat(m_cnt[m][4] + ((v && mq) ? 1 : 0), m_max[m]);
                if (halt_now) begin
                    m_st[m] = 2; m_done[m] = 1; m_hpc[m] = p;
                end else if (m_tmo[m] != 0 && m_cnt[m][0] == m_tmo[m]) begin
                    m_st[m] = 3; m_tout[m] = 1;
                end else begin
                    m_st[m] = 1;
                end
            end
        end
    endtask

    function automatic exp_t model_out(input int m);
        exp_t e;
        e.st   = 2'(m_st[m]);
        e.done = m_done[m];
        e.tout = m_tout[m];
        e.cyc  = 32'(m_cnt[m][0]);
        e.ins  = 32'(m_cnt[m][1]);
        e.bub  = 32'(m_cnt[m][2]);
        e.ctl  = 32'(m_cnt[m][3]);
        e.mis  = 32'(m_cnt[m][4]);
        e.hpc  = m_hpc[m];
        return e;
    endfunction

    task automatic drive(input bit r, input bit c, input bit v, input logic [31:0] p,
                         input bit ct, input bit mq);
        @(negedge clk);
        rst = r; clr = c; vld = v; pc = p; ctl = ct; mp = mq;
        model_step(r, c, v, p, ct, mq);
        qa.push_back(model_out(0));
        qb.push_back(model_out(1));
    endtask

    task automatic ret(input logic [31:0] p);
        drive(1, 0, 1, p, 0, 0);
    endtask

    task automatic bubble();
        drive(1, 0, 0, $urandom, 1'($urandom), 1'($urandom));
    endtask

    task automatic do_clear();
        drive(1, 1, 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint got, input longint want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Monitor: every cycle the DUTs present a full output set; compare against the queued expectation.
    initial begin
        exp_t ga, gb, ea, eb;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                ea = qa.pop_front();
                ga = {st_a, done_a, tout_a, cyc_a, ins_a, bub_a, ctl_a, mis_a, hpc_a};
                n_tests++;
                if (ga !== ea) begin
                    n_fail++;
                    $display("FAIL sb_a @%0t: got %h, expected %h", $time, ga, ea);
                end
            end
            if (qb.size() > 0) begin
                eb = qb.pop_front();
                gb = {st_b, done_b, tout_b, 32'(cyc_b), 32'(ins_b), 32'(bub_b),
                      32'(ctl_b), 32'(mis_b), hpc_b};
                n_tests++;
                if (gb !== eb) begin
                    n_fail++;
                    $display("FAIL sb_b @%0t: got %h, expected %h", $time, gb, eb);
                end
            end
        end
    end

    initial begin
        // Reset with random inputs
        for (int i = 0; i < 5; i++)
            drive(0, 1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
        settle();
        chk("reset_state", st_a, 0);
        chk("reset_cycles", cyc_a, 0);
        chk("reset_done_tout", {done_a, tout_a}, 0);
        for (int i = 0; i < 10; i++) bubble();
        settle();
        chk("idle_state", st_a, 0);
        chk("idle_bubbles", bub_a, 0);

        // Normal halt
        ret(32'h0); ret(32'h4); bubble();
        drive(1, 0, 1, 32'h8, 1, 1);
        for (int i = 0; i < 4; i++) ret(32'h40);
        settle();
        chk("halt_state", st_a, 2);
        chk("halt_cycles", cyc_a, 8);
        chk("halt_insns", ins_a, 7);
        chk("halt_bubbles", bub_a, 1);
        chk("halt_ctrl", ctl_a, 1);
        chk("halt_mispred", mis_a, 1);
        chk("halt_pc", hpc_a, 32'h40);
        for (int i = 0; i < 20; i++)
            drive(1, 0, 1'($urandom), $urandom_range(0, 3) * 4, 1'($urandom), 1'($urandom));
        settle();
        chk("frozen_cycles", cyc_a, 8);

        // Bubbles inside the repeat
        do_clear();
        ret(32'h40); ret(32'h40); bubble(); bubble(); ret(32'h40); ret(32'h40);
        settle();
        chk("bub_rep_done", done_a, 1);
        chk("bub_rep_bubbles", bub_a, 2);
        do_clear();
        ret(32'h40); ret(32'h40); ret(32'h44); ret(32'h40);
        for (int i = 0; i < 3; i++) bubble();
        settle();
        chk("broken_rep_state", st_a, 1);
        chk("broken_rep_done", done_a, 0);

        // Watchdog
        do_clear();
        for (int i = 0; i < 100; i++) ret(32'h100 + 32'(i) * 4);
        settle();
        chk("wdog_state", st_a, 3);
        chk("wdog_timeout", tout_a, 1);
        chk("wdog_cycles", cyc_a, 100);
        chk("wdog_insns", ins_a, 100);
        for (int i = 0; i < 10; i++) ret(32'h1000 + 32'(i) * 4);
        settle();
        chk("wdog_frozen", cyc_a, 100);

        // Halt and watchdog on the same cycle
        do_clear();
        for (int i = 0; i < 96; i++) ret(32'h2000 + 32'(i) * 4);
        for (int i = 0; i < 4; i++) ret(32'h9000);
        settle();
        chk("simul_state", st_a, 2);
        chk("simul_done", done_a, 1);
        chk("simul_timeout", tout_a, 0);

        // Saturation (4-bit instance) and clear
        do_clear();
        for (int i = 0; i < 20; i++) ret(32'h3000 + 32'(i) * 4);
        settle();
        chk("sat_cycles", cyc_b, 15);
        chk("sat_insns", ins_b, 15);
        chk("sat_state", st_b, 1);
        do_clear();
        settle();
        chk("clear_state", st_b, 0);
        chk("clear_cycles", cyc_b, 0);

        // Random traffic with a small PC set so self-loops occur
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 999);
            drive((r < 5) ? 1'b0 : 1'b1, (r >= 5 && r < 25) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 9) < 7), $urandom_range(0, 2) * 4,
                  1'($urandom), 1'($urandom));
        end

        settle();
        settle();
        chk("queue_a_drained", qa.size(), 0);
        chk("queue_b_drained", qb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
